point_sort_ctrl: RTL
====================

Name: point_sort_ctrl

Overview:
- Controller that sequences the point-set datapath: collects LENGTH (X,Y) points, schedules pairwise angle compares and swaps, then streams the points out in order.
- Owns the index registers, pass counters and out_valid.
- The register file and the cross-product compare live in the datapath; this block only drives its indices and enables.
- The datapath compare is combinational. It reports whether the pair at (cmp_i, cmp_j) is out of order relative to pivot point 0.

Parameters:
- LENGTH, 6, number of points per set; legal range 3..255.
- IDX_W, 8, width of all index ports; must satisfy 2^IDX_W > LENGTH.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- give_valid  in  1  one input point is present on the datapath bus this cycle.
- cmp_swap  in  1  datapath result: pair (cmp_i, cmp_j) must be exchanged.
- wr_en  out  1  datapath writes the input point at wr_idx.
- wr_idx  out  IDX_W  load index.
- cmp_en  out  1  compare slot active.
- cmp_i  out  IDX_W  first compare index.
- cmp_j  out  IDX_W  second compare index; always cmp_i+1.
- swap_en  out  1  datapath exchanges entries cmp_i and cmp_j at this clock edge.
- rd_idx  out  IDX_W  output read index.
- out_valid  out  1  ansX/ansY are valid for entry rd_idx.
- busy  out  1  high in SORT and OUT; give_valid is ignored while high.

Behaviour:
- Reset (async, reset=0):
  - state=LOAD; wr_idx, cmp_i, cmp_j, rd_idx = 0.
  - wr_en, cmp_en, swap_en, out_valid, busy = 0.
  - Pass and compare counters cleared.
- States: LOAD -> SORT -> OUT -> LOAD.
- LOAD:
  - wr_en = give_valid (combinational).
  - Each give_valid cycle increments wr_idx.
  - On the LENGTH-th accepted point: wr_idx returns to 0 and state moves to SORT on the same edge.
  - Gaps in give_valid are allowed; there is no timeout.
- SORT: bubble sort over entries 1..LENGTH-1. Entry 0 is the pivot and is never compared.
  - Pass p runs for p = 0..LENGTH-3.
  - Within pass p, one compare per cycle, cmp_i = 1..LENGTH-2-p, with cmp_en=1.
  - swap_en = cmp_en & cmp_swap (combinational).
  - Total compares = (LENGTH-1)(LENGTH-2)/2; 10 for LENGTH=6. No idle cycles between passes.
  - After the last compare, state moves to OUT.
- OUT:
  - out_valid=1 for exactly LENGTH consecutive cycles, rd_idx = 0..LENGTH-1.
  - After the cycle with rd_idx=LENGTH-1: out_valid=0, rd_idx=0, state=LOAD.
  - No backpressure.
- Latency (LENGTH=6):
  - Last give_valid accepted at edge E.
  - SORT compares occupy cycles E+1..E+10.
  - out_valid is first high in cycle E+11 and last high in cycle E+16.
  - busy is high in cycles E+1..E+16.
- cmp_swap is ignored outside SORT.
- give_valid is ignored in SORT/OUT: no write, no counter change.
- Reset asserted mid-SORT or mid-OUT aborts immediately; the next set starts at wr_idx=0.
- The datapath register contents are not this block's concern.
- LENGTH=3: one pass with a single compare (1,2).

Optional Feature:
- Macro: POINT_SORT_EARLY_EXIT_EN.
- Defined:
  - A per-pass flag records any swap_en.
  - If a pass completes with no swap, SORT ends and OUT starts next cycle.
  - An already sorted 6-point set gives 4 compare cycles, with out_valid starting at E+5.
- Undefined: full fixed schedule, constant latency; no flag register is synthesized.

Decomposition:
- Shared package point_pkg:
  - state encoding enum {LOAD, SORT, OUT};
  - default LENGTH = 6;
  - idx_t typedef of IDX_W bits.
- One natural sub-module, sort_index_gen:
  - owns the pass and compare counters;
  - emits cmp_i, cmp_j, cmp_en and sort_done;
  - holds the early-exit flag when enabled.
- The top-level FSM handles LOAD/OUT and the handshakes.

Test Plan:
- Reset then 6 give_valid back-to-back -> wr_en/wr_idx 0..5; busy rises next cycle; cmp_i sequence 1,2,3,4,1,2,3,1,2,1; out_valid high 6 cycles starting E+11 with rd_idx 0..5.
- give_valid with 2-cycle gaps between points -> wr_idx advances only on valid cycles; SORT starts only after the 6th point.
- give_valid held high during SORT and OUT -> wr_en stays 0 and wr_idx stays 0; the next set loads normally after OUT.
- cmp_swap tied 1 -> swap_en high on all 10 compare cycles; cmp_swap tied 0 -> swap_en never high; both cases give identical timing.
- Reset pulsed at the 4th compare cycle -> all outputs 0 asynchronously; a fresh 6-point load then completes with nominal timing.
- With POINT_SORT_EARLY_EXIT_EN and cmp_swap=0 -> 4 compares, then out_valid at E+5. With cmp_swap=1 only on the first compare -> 4+3 compares, out_valid at E+8.

Source files
------------

// File: rtl/point_pkg.sv
// ---------------------------------------------------------------------------
// point_pkg
// Shared definitions for the point-set sort controller: default set size,
// index width, the index type and the controller state encoding.
// ---------------------------------------------------------------------------
package point_pkg;

    localparam int unsigned LENGTH_DEF = 6;
    localparam int unsigned IDX_W_DEF  = 8;

    typedef logic [IDX_W_DEF-1:0] idx_t;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/sort_index_gen.sv
// ---------------------------------------------------------------------------
// sort_index_gen
// Bubble-sort compare scheduler over entries 1..LENGTH-1 (entry 0 is the
// pivot and never takes part). One compare per cycle while run is high, with
// no idle cycles between passes. Pass p covers cmp_i = 1..LENGTH-2-p.
//
// Ports:
//   clk, reset  clock, asynchronous active-low reset
//   run         controller is in SORT
//   swap_en     (POINT_SORT_EARLY_EXIT_EN only) swap taken this cycle
//   cmp_en      compare slot active
//   cmp_i/cmp_j compare pair, cmp_j = cmp_i + 1; both 0 when idle
//   sort_done   high during the final compare cycle of the sort
//
// Build option: POINT_SORT_EARLY_EXIT_EN ends the sort after the first pass
// that performs no swap.
// ---------------------------------------------------------------------------
module sort_index_gen
    import point_pkg::*;
#(
    parameter int unsigned LENGTH = LENGTH_DEF,
    parameter int unsigned IDX_W  = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
`ifdef POINT_SORT_EARLY_EXIT_EN
    input  logic             swap_en,
`endif
    output logic             cmp_en,
    output logic [IDX_W-1:0] cmp_i,
    output logic [IDX_W-1:0] cmp_j,
    output logic             sort_done
);

    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
    localparam logic [IDX_W-1:0] TOP_IDX   = IDX_W'(LENGTH - 2);
    localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(LENGTH - 3);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] pass_q, pass_d;
    logic             pass_end;
    logic             last_pass;

    // Pass p ends at index LENGTH-2-p.
    assign pass_end  = (idx_q == (TOP_IDX - pass_q));
    assign last_pass = (pass_q == LAST_PASS);

`ifdef POINT_SORT_EARLY_EXIT_EN
    logic swapped_q, swapped_d;

    // A pass with no swap (including this cycle's compare) proves the set sorted.
    assign sort_done = run & pass_end & (last_pass | ~(swapped_q | swap_en));

    always_comb begin
        swapped_d = swapped_q;
        if (!run || pass_end) begin
            swapped_d = 1'b0;
        end else begin
            swapped_d = swapped_q | swap_en;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            swapped_q <= 1'b0;
        end else begin
            swapped_q <= swapped_d;
        end
    end
`else
    assign sort_done = run & pass_end & last_pass;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        idx_d  = idx_q;
        pass_d = pass_q;
        if (!run || sort_done) begin
            idx_d  = FIRST_IDX;
            pass_d = '0;
        end else if (pass_end) begin
            idx_d  = FIRST_IDX;
            pass_d = pass_q + IDX_W'(1);
        end else begin
            idx_d  = idx_q + IDX_W'(1);
        end
    end

    // NOTE: the reset edge is in the sensitivity list so reset acts without a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            idx_q  <= FIRST_IDX;
            pass_q <= '0;
        end else begin
            idx_q  <= idx_d;
            pass_q <= pass_d;
        end
    end

    assign cmp_en = run;
    assign cmp_i  = run ? idx_q : '0;
    assign cmp_j  = run ? (idx_q + IDX_W'(1)) : '0;

endmodule

// File: rtl/point_sort_ctrl.sv
// ---------------------------------------------------------------------------
// point_sort_ctrl
// Sequences the point-set datapath: LOAD collects LENGTH points, SORT runs the
// bubble-sort compare schedule on entries 1..LENGTH-1, OUT streams all
// LENGTH entries, then back to LOAD.
//
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   give_valid   input point present (ignored while busy)
//   cmp_swap     datapath says pair (cmp_i, cmp_j) is out of order
//   wr_en/wr_idx datapath load strobe and index
//   cmp_en, cmp_i, cmp_j  compare slot and pair
//   swap_en      datapath exchanges cmp_i/cmp_j at this edge
//   rd_idx, out_valid     output stream index and qualifier
//   busy         high in SORT and OUT
//
// Build option: POINT_SORT_EARLY_EXIT_EN stops sorting after a swap-free pass.
// ---------------------------------------------------------------------------
module point_sort_ctrl
    import point_pkg::*;
#(
    parameter int unsigned LENGTH = LENGTH_DEF,
    parameter int unsigned IDX_W  = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             give_valid,
    input  logic             cmp_swap,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_idx,
    output logic             cmp_en,
    output logic [IDX_W-1:0] cmp_i,
    output logic [IDX_W-1:0] cmp_j,
    output logic             swap_en,
    output logic [IDX_W-1:0] rd_idx,
    output logic             out_valid,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             sort_done;

    assign wr_en   = give_valid & (state_q == LOAD);
    assign swap_en = cmp_en & cmp_swap;

    sort_index_gen #(
        .LENGTH (LENGTH),
        .IDX_W  (IDX_W)
    ) u_index_gen (
        .clk       (clk),
        .reset     (reset),
        .run       (state_q == SORT),
`ifdef POINT_SORT_EARLY_EXIT_EN
        .swap_en   (swap_en),
`endif
        .cmp_en    (cmp_en),
        .cmp_i     (cmp_i),
        .cmp_j     (cmp_j),
        .sort_done (sort_done)
    );

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            LOAD: begin
                if (give_valid) begin
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        state_d  = SORT;
                        busy_d   = 1'b1;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end
                end
            end
            SORT: begin
                if (sort_done) begin
                    state_d     = OUT;
                    out_valid_d = 1'b1;
                    rd_idx_d    = '0;
                end
            end
            OUT: begin
                if (rd_idx_q == LAST_IDX) begin
                    state_d     = LOAD;
                    out_valid_d = 1'b0;
                    rd_idx_d    = '0;
                    busy_d      = 1'b0;
                end else begin
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d     = LOAD;
                wr_idx_d    = '0;
                rd_idx_d    = '0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= LOAD;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign wr_idx    = wr_idx_q;
    assign rd_idx    = rd_idx_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
